// File: rtl/booth_mult8_core_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult8_core_pipelined
// Description : Multi-cycle 8x8 multiplier using radix-4 Booth recoding.
//               Each operand is independently treated as signed or unsigned,
//               extended to 10 bits, and multiplied over five Booth digit
//               steps. The 16-bit product and a one-cycle done strobe are
//               registered outputs.
// Ports       : clk          - clock, rising edge active
//               rst_n        - synchronous reset, active HIGH
//               start        - operation request, accepted only when idle
//               multiplicand - operand A (8 bits)
//               multiplier   - operand B (8 bits)
//               sign_mode    - [1]: A signed, [0]: B signed
//               product      - low 16 bits of A_ext * B_ext (registered)
//               done         - one-cycle completion strobe (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mult8_core_pipelined (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         multiplicand,
  input  logic [7:0]         multiplier,
  input  logic [1:0]         sign_mode,
  output logic signed [15:0] product,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST_DIGIT = 3'd4;

  state_t             state_q;
  logic [7:0]         a_raw_q;
  logic [7:0]         b_raw_q;
  logic [1:0]         mode_q;
  // Multiplicand pre-scaled by 4^digit; shifted left two places per step.
  logic signed [19:0] mcand_q;
  // Extended multiplier with an appended zero (the b[-1] Booth bit);
  // shifted right two places per step so the current triplet sits in [2:0].
  logic [10:0]        mplr_q;
  logic signed [19:0] acc_q;
  logic signed [19:0] acc_d;
  logic signed [19:0] pp_d;
  logic [2:0]         cnt_q;
  logic [15:0]        product_q;
  logic               done_q;

  // Booth digit selection from the current multiplier triplet.
  always_comb begin
    pp_d = '0;
    case (mplr_q[2:0])
      3'b001, 3'b010: pp_d = mcand_q;
      3'b011:         pp_d = mcand_q <<< 1;
      3'b100:         pp_d = -(mcand_q <<< 1);
      3'b101, 3'b110: pp_d = -mcand_q;
      default:        pp_d = '0;
    endcase
    acc_d = acc_q + pp_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      a_raw_q   <= '0;
      b_raw_q   <= '0;
      mode_q    <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_raw_q <= multiplicand;
            b_raw_q <= multiplier;
            mode_q  <= sign_mode;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          mcand_q <= {{12{mode_q[1] & a_raw_q[7]}}, a_raw_q};
          mplr_q  <= {{2{mode_q[0] & b_raw_q[7]}}, b_raw_q, 1'b0};
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q <<< 2;
          mplr_q  <= {{2{mplr_q[10]}}, mplr_q[10:2]};
          cnt_q   <= cnt_q + 3'd1;
          if (cnt_q == LAST_DIGIT) begin
            // Only the final sum is published; partial sums stay internal.
            product_q <= acc_d[15:0];
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          // Start is deliberately not sampled here.
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign product = product_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult8_core_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mult8_core_pipelined
// Description : Self-checking bench for booth_mult8_core_pipelined with a
//               cycle-level behavioural reference model and literal corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult8_core_pipelined;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [1:0]  sign_mode;
  logic [15:0] product;
  logic        done;

  int checks   = 0;
  int failures = 0;
  bit en_cmp   = 1'b0;

  booth_mult8_core_pipelined dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .sign_mode    (sign_mode),
    .product      (product),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Low 16 bits of the exact product of the extended operands.
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m);
    int ia;
    int ib;
    int p;
    ia = (m[1] && a[7]) ? int'(a) - 256 : int'(a);
    ib = (m[0] && b[7]) ? int'(b) - 256 : int'(b);
    p  = ia * ib;
    return p[15:0];
  endfunction

  // Reference model: an accepted request in idle produces its result six
  // edges later and the unit is busy for seven edges in total.
  int          m_timer = 0;
  logic [15:0] m_prod  = 16'h0000;
  logic        m_done  = 1'b0;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic [1:0]  m_mode;

  always @(posedge clk) begin
    if (rst_n) begin
      m_timer = 0;
      m_prod  = 16'h0000;
      m_done  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_timer == 0) begin
        if (start) begin
          m_a     = multiplicand;
          m_b     = multiplier;
          m_mode  = sign_mode;
          m_timer = 7;
        end
      end else begin
        m_timer = m_timer - 1;
        if (m_timer == 1) begin
          m_prod = ref_mul(m_a, m_b, m_mode);
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (en_cmp) begin
      checks++;
      if (done !== m_done || product !== m_prod) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t done=%b product=%h required done=%b product=%h",
                 $time, done, product, m_done, m_prod);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request, scramble inputs while busy, wait for done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                        input logic [15:0] exp, input string name, input bit chk_lat);
    int seen;
    seen = 0;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    sign_mode    = m;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    sign_mode    = 2'($urandom);
    for (int i = 2; i <= 14; i++) begin
      @(negedge clk);
      if (done) begin
        seen = i;
        break;
      end
    end
    if (seen == 0) begin
      failures++;
      checks++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end else begin
      check(name, product, exp);
      if (chk_lat) check({name, "_latency"}, 16'(seen), 16'd7);
    end
  endtask

  initial begin
    int dcount;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] rm;

    rst_n        = 1'b1;
    start        = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    sign_mode    = 2'b00;
    repeat (2) @(negedge clk);
    en_cmp = 1'b1;
    check("reset_product", product, 16'h0000);
    check("reset_done", {15'd0, done}, 16'h0000);
    rst_n = 1'b0;

    // Start immediately after reset release.
    run_op(8'd3, 8'd5, 2'b00, 16'd15, "first_after_reset", 1'b1);

    // Corners with hand-computed results.
    run_op(8'h80, 8'h80, 2'b11, 16'h4000, "s_s_80x80", 1'b1);
    run_op(8'h7F, 8'h80, 2'b11, 16'hC080, "s_s_7Fx80", 1'b0);
    run_op(8'hFF, 8'hFF, 2'b01, 16'hFF01, "u_s_FFxFF", 1'b0);
    run_op(8'h80, 8'hFF, 2'b10, 16'h8080, "s_u_80xFF", 1'b0);
    run_op(8'hFF, 8'hFF, 2'b00, 16'hFE01, "u_u_FFxFF", 1'b0);
    run_op(8'hA5, 8'h00, 2'b11, 16'h0000, "any_x00", 1'b0);
    run_op(8'h00, 8'h9C, 2'b01, 16'h0000, "zero_x", 1'b0);
    run_op(8'hFF, 8'h02, 2'b10, 16'hFFFE, "s_u_m1x2", 1'b0);

    // Busy start at E2 must be ignored; exactly one done is expected.
    @(negedge clk);
    multiplicand = 8'd12; multiplier = 8'd11; sign_mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    multiplicand = 8'd99; multiplier = 8'd77; sign_mode = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        check("busy_start_product", product, 16'd132);
      end
    end
    check("busy_start_done_count", 16'(dcount), 16'd1);

    // Reset at E3 aborts the operation with no done pulse.
    @(negedge clk);
    multiplicand = 8'd200; multiplier = 8'd3; sign_mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_done_count", 16'(dcount), 16'd0);
    check("abort_product", product, 16'h0000);
    run_op(8'hF0, 8'h10, 2'b10, 16'hFF00, "after_abort", 1'b1);

    // Start held high: back-to-back operations with inputs changing each cycle.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      sign_mode    = 2'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Random operations.
    for (int n = 0; n < 1500; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 2'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'h00;
      run_op(ra, rb, rm, ref_mul(ra, rb, rm), "random", 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    en_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_mult8_core_pipelined.md
BOOTH_MULT8_CORE_PIPELINED -- requirements
Module: booth_mult8_core_pipelined

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-high reset (asserted when 1, sampled on rising clk edge).
REQ-004 start  input  1  request; sampled on rising edge; one-cycle pulse is sufficient.
REQ-005 multiplicand  input  8  operand A.
REQ-006 multiplier  input  8  operand B.
REQ-007 sign_mode  input  2  bit[1]=1: A signed (two's complement), else unsigned; bit[0]=1: B signed, else unsigned.
REQ-008 product  output  16 (signed)  result, registered.
REQ-009 done  output  1  registered completion strobe.

Function
REQ-010 Operands and sign_mode SHALL be captured into internal registers on the edge where start=1 and the block is idle; later input changes SHALL NOT affect that operation.
REQ-011 Each captured operand SHALL be extended to 10 bits: sign-extended if its sign_mode bit is 1, zero-extended otherwise.
REQ-012 Multiplication SHALL use radix-4 Booth recoding of the 10-bit extended multiplier: 5 digit steps, digits in {-2,-1,0,+1,+2}, each partial product added into an accumulator of at least 18 bits.
REQ-013 Result SHALL be the low 16 bits of the exact mathematical product A_ext*B_ext (unsigned x unsigned results above 0x7FFF wrap into the 16-bit field, e.g. 255*255 -> 0xFE01).
REQ-014 States: IDLE -> LOAD (capture/extend) -> ITER (5 cycles, one Booth digit per cycle) -> DONE -> IDLE.
REQ-015 Latency: start sampled at edge E0; product updated and done=1 at edge E6; done SHALL be high for exactly one clock cycle.
REQ-016 product SHALL remain stable from E6 until the next operation's E6 or reset; it SHALL NOT show intermediate accumulator values.
REQ-017 start asserted while not in IDLE SHALL be ignored (no restart, no queuing).
REQ-018 start asserted in the DONE cycle SHALL be ignored; start in IDLE the cycle after DONE SHALL be accepted.
REQ-019 start held high continuously SHALL launch back-to-back operations, each accepted in IDLE.
REQ-020 done SHALL not assert without a preceding accepted start.

Reset
REQ-021 While rst_n=1 at a rising edge: state -> IDLE, product -> 0x0000, done -> 0, internal registers cleared.
REQ-022 Reset SHALL have priority over start; reset mid-operation SHALL abort it with no done pulse.
REQ-023 After reset release, first start SHALL be accepted on the next rising edge with start=1.

Verification
REQ-024 Exhaustive: all 256x256 A/B for each of the 4 sign_mode values, start pulse, wait done -> product equals low 16 bits of extended-operand product (262144 checks, zero mismatches).
REQ-025 Corners: mode 11, 0x80*0x80 -> 0x4000; mode 11, 0x7F*0x80 -> 0xC080; mode 01, 0xFF*0xFF -> 0xFF01; mode 10, 0x80*0xFF -> 0x8080; mode 00, 0xFF*0xFF -> 0xFE01; any *0x00 -> 0x0000.
REQ-026 Latency: start at edge E0 -> done=1 only in cycle after E6, done=0 at E7; product holds afterward.
REQ-027 Busy start: second start at E2 with different operands -> ignored; first result reported at E6, no extra done.
REQ-028 Reset mid-op: rst_n=1 at E3 -> product 0x0000, done never pulses; fresh start afterward completes correctly.
REQ-029 Random: 50000 random A, B, sign_mode, sign_mode changed with each start -> all results correct.
